// File: rtl/alu_pkg.sv
// Shared ALU control encodings and the multiply/divide sequencer's enums.
package alu_pkg;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_SLT   = 3'b101;
    localparam logic [2:0] ALU_PASSB = 3'b110;

    typedef enum logic [1:0] {
        MUL   = 2'b00,
        MULHU = 2'b01,
        DIVU  = 2'b10,
        REMU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } seq_state_t;

endpackage

// File: rtl/alu.sv
// Core's shared combinational ALU; borrowed by alu_muldiv_seq while it is busy.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [2:0]       ALUControl,
    output logic [WIDTH-1:0] ALUResult
);

    always_comb begin
        ALUResult = '0;
        case (ALUControl)
            ALU_ADD:   ALUResult = SrcA + SrcB;
            ALU_SUB:   ALUResult = SrcA - SrcB;
            ALU_AND:   ALUResult = SrcA & SrcB;
            ALU_OR:    ALUResult = SrcA | SrcB;
            ALU_SLT:   ALUResult = {{(WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
            ALU_PASSB: ALUResult = SrcB;
            default:   ALUResult = '0;
        endcase
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU sequencer that issues one add or subtract
// per cycle to the shared ALU (shift-add multiply, restoring divide).
module alu_muldiv_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] AluSrcA,
    output logic [WIDTH-1:0] AluSrcB,
    output logic [2:0]       AluControl,
    input  logic [WIDTH-1:0] AluResult
);

    seq_state_t       state;
    muldiv_op_t       op_r;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] opnd;
    logic [5:0]       cnt;

    logic             is_div;
    logic             top;
    logic             carry;
    logic             accept;
    logic [WIDTH-1:0] shr;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] final_val;

    assign is_div = (op_r == DIVU) || (op_r == REMU);

    always_comb begin
        top    = acc[WIDTH-1];
        shr    = {acc[WIDTH-2:0], q[WIDTH-1]};
        sum    = q[0] ? AluResult : acc;
        // Carry out of acc + opnd, recovered from the 32-bit ALU sum.
        carry  = q[0] & (AluResult < acc);
        // A set top bit means the 33-bit remainder always exceeds the divisor.
        accept = top | (shr >= opnd);
        if (is_div) begin
            acc_nxt = accept ? AluResult : shr;
            q_nxt   = {q[WIDTH-2:0], accept};
        end else begin
            acc_nxt = {carry, sum[WIDTH-1:1]};
            q_nxt   = {sum[0], q[WIDTH-1:1]};
        end
        case (op_r)
            MUL:     final_val = q_nxt;
            MULHU:   final_val = acc_nxt;
            DIVU:    final_val = q_nxt;
            REMU:    final_val = acc_nxt;
            default: final_val = q_nxt;
        endcase
    end

    always_comb begin
        AluSrcA    = '0;
        AluSrcB    = '0;
        AluControl = ALU_ADD;
        if (state == RUN) begin
            AluSrcA    = is_div ? shr : acc;
            AluSrcB    = opnd;
            AluControl = is_div ? ALU_SUB : ALU_ADD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            op_r   <= MUL;
            acc    <= '0;
            q      <= '0;
            opnd   <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            Result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r <= muldiv_op_t'(op);
                        acc  <= '0;
                        cnt  <= '0;
                        busy <= 1'b1;
                        if (op[1]) begin
                            q    <= OpA;
                            opnd <= OpB;
                            if (OpB == '0) begin
                                state  <= DONE;
                                done   <= 1'b1;
                                Result <= (muldiv_op_t'(op) == DIVU) ? {WIDTH{1'b1}} : OpA;
                            end else begin
                                state <= RUN;
                            end
                        end else begin
                            q     <= OpB;
                            opnd  <= OpA;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    q   <= q_nxt;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        Result <= final_val;
                        cnt    <= '0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench: alu_muldiv_seq wired to the real alu, checked against a
// plain-arithmetic reference model with directed and random operations.
module tb_alu_muldiv_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] OpA = '0;
    logic [31:0] OpB = '0;
    logic        busy;
    logic        done;
    logic [31:0] Result;
    logic [31:0] AluSrcA;
    logic [31:0] AluSrcB;
    logic [2:0]  AluControl;
    logic [31:0] AluResult;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_prev = '0;

    always #5 clk = ~clk;

    alu_muldiv_seq #(.WIDTH(32)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .OpA        (OpA),
        .OpB        (OpB),
        .busy       (busy),
        .done       (done),
        .Result     (Result),
        .AluSrcA    (AluSrcA),
        .AluSrcB    (AluSrcB),
        .AluControl (AluControl),
        .AluResult  (AluResult)
    );

    alu #(.WIDTH(32)) u_alu (
        .SrcA       (AluSrcA),
        .SrcB       (AluSrcB),
        .ALUControl (AluControl),
        .ALUResult  (AluResult)
    );

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (o)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Called at a negedge; start is sampled at the next posedge (edge 0).
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int start_at, input int rst_at);
        logic [31:0] exp;
        int          done_cyc;
        bit          in_rst;
        exp      = model(o, a, b);
        done_cyc = (o[1] && b == 0) ? 1 : 33;
        in_rst   = 1'b0;
        op       = o;
        OpA      = a;
        OpB      = b;
        start    = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (rst) rst = 1'b0;
            if (!in_rst) begin
                check($sformatf("busy c%0d", c), 96'(busy), 96'(c <= done_cyc));
                check($sformatf("done c%0d", c), 96'(done), 96'(c == done_cyc));
                check($sformatf("result c%0d", c), 96'(Result),
                      96'((c < done_cyc) ? exp_prev : exp));
                if (c < done_cyc) begin
                    check($sformatf("alu ctl c%0d", c), 96'(AluControl),
                          96'(o[1] ? ALU_SUB : ALU_ADD));
                    check($sformatf("alu srcb c%0d", c), 96'(AluSrcB), 96'(o[1] ? b : a));
                end else begin
                    check($sformatf("alu idle c%0d", c),
                          96'({AluSrcA, AluSrcB, AluControl}), 96'(0));
                end
                if (c == done_cyc + 1) break;
            end else begin
                check($sformatf("rst busy c%0d", c), 96'(busy), 96'(0));
                check($sformatf("rst done c%0d", c), 96'(done), 96'(0));
                check($sformatf("rst result c%0d", c), 96'(Result), 96'(0));
                if (c == rst_at + 3) break;
            end
            if (c == rst_at) begin
                rst = 1'b1;
                #1;
                in_rst = 1'b1;
                check("async rst", 96'({busy, done, Result, AluSrcA, AluSrcB, AluControl}),
                      96'(0));
            end
            if (c == 1) start = 1'b0;
            if (c == start_at) begin
                start = 1'b1;
                op    = 2'($urandom);
                OpA   = $urandom;
                OpB   = $urandom;
            end else if (c == start_at + 1) begin
                start = 1'b0;
            end
        end
        start    = 1'b0;
        exp_prev = in_rst ? 32'h0 : exp;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  o;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset busy", 96'(busy), 96'(0));
        check("reset done", 96'(done), 96'(0));
        check("reset result", 96'(Result), 96'(0));
        check("reset alu", 96'({AluSrcA, AluSrcB, AluControl}), 96'(0));

        run_op(2'd0, 32'd7, 32'd6, 0, 0);
        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_op(2'd2, 32'd100, 32'd7, 0, 0);
        run_op(2'd3, 32'd100, 32'd7, 0, 0);
        run_op(2'd2, 32'hFFFF_FFFF, 32'd1, 0, 0);
        run_op(2'd3, 32'h8000_0000, 32'd3, 0, 0);
        run_op(2'd2, 32'd123, 32'd0, 0, 0);
        run_op(2'd3, 32'd123, 32'd0, 0, 0);
        run_op(2'd0, 32'h0001_2345, 32'h0000_6789, 10, 0);
        run_op(2'd2, 32'hDEAD_BEEF, 32'd17, 0, 15);
        run_op(2'd1, 32'h89AB_CDEF, 32'h7654_3210, 0, 0);

        for (int i = 0; i < 16; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = 32'($urandom_range(1, 255));
                2:       b = 32'h0;
                default: b = 32'hFFFF_FFFF;
            endcase
            run_op(o, a, b, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
